// File: rtl/mem_packet_server_pkg.sv
// Shared constants, packet field layout and the queued request type for
// the memory-side endpoint of the memory_controller packet link.
package mem_pkt_pkg;

    localparam int DATA_WIDTH_BYTE = 4;
    localparam int ADDR_WIDTH_BYTE = 4;
    localparam int MEM_ADDR_WIDTH  = 12;

    localparam int DW        = DATA_WIDTH_BYTE * 8;
    localparam int AW        = ADDR_WIDTH_BYTE * 8;
    localparam int SEND_BYTE = DATA_WIDTH_BYTE + ADDR_WIDTH_BYTE + DATA_WIDTH_BYTE / 8 + 1;
    localparam int SEND_W    = SEND_BYTE * 8;

    // Field offsets inside a write packet; a read packet carries only the address at bit 0.
    localparam int WR_DATA_LSB = 0;
    localparam int WR_ADDR_LSB = DW;
    localparam int WR_MASK_LSB = DW + AW;
    localparam int RD_ADDR_LSB = 0;

    // Byte address -> word address: drop the byte-in-word bits.
    localparam int WORD_LSB = $clog2(DATA_WIDTH_BYTE);

    localparam logic [4:0] READ_LEN  = 5'(ADDR_WIDTH_BYTE + 1);
    localparam logic [4:0] WRITE_LEN = 5'(SEND_BYTE);
    localparam logic [4:0] RESP_LEN  = 5'(DATA_WIDTH_BYTE);

    typedef struct packed {
        logic                       is_write;
        logic [MEM_ADDR_WIDTH-1:0]  addr;
        logic [DW-1:0]              data;
        logic [DATA_WIDTH_BYTE-1:0] mask;
    } mem_req_t;

    // Upper address bits beyond the SRAM are ignored, so addresses wrap.
    function automatic logic [MEM_ADDR_WIDTH-1:0] word_addr(input logic [AW-1:0] byte_addr);
        return byte_addr[WORD_LSB +: MEM_ADDR_WIDTH];
    endfunction

endpackage

// File: rtl/mem_packet_server_if.sv
// Packet link between memory_controller (master) and mem_packet_server (slave).
interface mem_packet_server_if;
    import mem_pkt_pkg::*;

    logic              send_flag;
    logic [SEND_W-1:0] send_data;
    logic [4:0]        send_length;
    logic              sendable;
    logic              receivable;
    logic              recv_flag;
    logic [SEND_W-1:0] recv_data;
    logic [4:0]        recv_length;

    modport master (
        output send_flag, send_data, send_length, recv_flag,
        input  sendable, receivable, recv_data, recv_length
    );

    modport slave (
        input  send_flag, send_data, send_length, recv_flag,
        output sendable, receivable, recv_data, recv_length
    );
endinterface

// File: rtl/mem_packet_server_req_fifo.sv
// Small synchronous FIFO of decoded requests; head is visible combinationally
// so the server can act on it in the same cycle it pops.
module mem_req_fifo
    import mem_pkt_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  mem_req_t push_req_i,
    input  logic     pop_i,
    output mem_req_t head_o,
    output logic     empty_o,
    output logic     full_o,
    output logic     full_d_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    mem_req_t        store_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CW'(DEPTH));
    assign do_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so push at full is taken then.
    assign do_push  = push_i && (!full_o || do_pop);
    assign head_o   = store_q[rd_ptr_q];
    assign full_d_o = (count_d == CW'(DEPTH));

    // Next fill level after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers and fill level; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= push_req_i;
    end
endmodule

// File: rtl/mem_packet_server.sv
// Memory-side packet endpoint: decodes request packets, queues them, executes
// them in order on a synchronous SRAM and holds read responses until consumed.
module mem_packet_server
    import mem_pkt_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mem_packet_server_if.slave         link,
    output logic                       mem_en,
    output logic [DATA_WIDTH_BYTE-1:0] mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic [DW-1:0]              mem_rdata,
    output logic                       err_overflow,
    output logic                       err_bad_len
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       capture;
    mem_req_t                   push_req, head;
    logic                       len_ok, push, pop;
    logic                       fifo_empty, fifo_full, fifo_full_d;
    logic                       sendable_q, receivable_q;
    logic [4:0]                 recv_len_q;
    logic [DW-1:0]              recv_data_q;
    logic                       mem_en_q;
    logic [DATA_WIDTH_BYTE-1:0] mem_we_q;
    logic [MEM_ADDR_WIDTH-1:0]  mem_addr_q;
    logic [DW-1:0]              mem_wdata_q;
    logic                       err_ovf_q, err_len_q;

    // Decode the incoming packet by its length; anything else is rejected.
    always_comb begin
        push_req = '0;
        len_ok   = 1'b0;
        if (link.send_length == READ_LEN) begin
            len_ok        = 1'b1;
            push_req.addr = word_addr(link.send_data[RD_ADDR_LSB +: AW]);
        end else if (link.send_length == WRITE_LEN) begin
            len_ok            = 1'b1;
            push_req.is_write = 1'b1;
            push_req.data     = link.send_data[WR_DATA_LSB +: DW];
            push_req.addr     = word_addr(link.send_data[WR_ADDR_LSB +: AW]);
            push_req.mask     = link.send_data[WR_MASK_LSB +: DATA_WIDTH_BYTE];
        end
    end

    assign pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign push = link.send_flag && len_ok && (!fifo_full || pop);

    mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_req_i (push_req),
        .pop_i      (pop),
        .head_o     (head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .full_d_o   (fifo_full_d)
    );

    // Sequencer: writes stay in IDLE, reads wait out the SRAM latency then hold a response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop && !head.is_write) begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = 3'(READ_LATENCY);
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (link.recv_flag) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered SRAM strobe: one cycle per popped request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= pop;
            mem_we_q <= (pop && head.is_write) ? head.mask : '0;
            if (pop) begin
                mem_addr_q  <= head.addr;
                mem_wdata_q <= head.data;
            end
        end
    end

    // Response register, held until the controller takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recv_data_q  <= '0;
            receivable_q <= 1'b0;
            recv_len_q   <= '0;
        end else if (capture) begin
            recv_data_q  <= mem_rdata;
            receivable_q <= 1'b1;
            recv_len_q   <= RESP_LEN;
        end else if ((state_q == ST_RESP) && link.recv_flag) begin
            receivable_q <= 1'b0;
            recv_len_q   <= '0;
        end
    end

    // Flow control and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sendable_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            sendable_q <= !fifo_full_d;
            if (link.send_flag && len_ok && fifo_full && !pop) err_ovf_q <= 1'b1;
            if (link.send_flag && !len_ok)                     err_len_q <= 1'b1;
        end
    end

    assign link.sendable    = sendable_q;
    assign link.receivable  = receivable_q;
    assign link.recv_length = recv_len_q;
    assign link.recv_data   = {{(SEND_W - DW){1'b0}}, recv_data_q};
    assign mem_en           = mem_en_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign err_overflow     = err_ovf_q;
    assign err_bad_len      = err_len_q;
endmodule
